pc_redirect_unit: RTL and testbench

- Owns the fetch PC register and sits directly downstream of the ID-stage branch comparator.
- Each cycle it selects the next PC from sequential, taken-branch, jump, jump-register or exception-vector sources.
- It generates the IF/ID flush.
- It buffers one redirect while instruction memory is not ready, so a taken branch is never lost.

---
 rtl/pc_redirect_unit_if.sv | 32 +++
 rtl/pc_redirect_unit.sv | 99 +++++++++
 tb/tb_pc_redirect_unit.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/pc_redirect_unit_if.sv
// rtl/pc_redirect_unit_if.sv - fetch redirect request/response bundle between ID stage and PC unit
interface pc_redirect_unit_if #(
  parameter int CNT_W = 16
);
  logic             Stall;
  logic             imem_ready;
  logic             Branch_Hazard;
  logic [31:0]      BranchTarget;
  logic             Jump;
  logic [31:0]      JumpTarget;
  logic             JumpReg;
  logic [31:0]      JrTarget;
  logic             Exception;
  logic [31:0]      PC;
  logic [31:0]      PC_plus4;
  logic             IFID_Flush;
  logic             fetch_valid;
  logic             redirect_pending;
  logic [CNT_W-1:0] taken_cnt;

  modport slave (
    input  Stall, imem_ready, Branch_Hazard, BranchTarget, Jump, JumpTarget,
           JumpReg, JrTarget, Exception,
    output PC, PC_plus4, IFID_Flush, fetch_valid, redirect_pending, taken_cnt
  );

  modport master (
    output Stall, imem_ready, Branch_Hazard, BranchTarget, Jump, JumpTarget,
           JumpReg, JrTarget, Exception,
    input  PC, PC_plus4, IFID_Flush, fetch_valid, redirect_pending, taken_cnt
  );
endinterface

// File: rtl/pc_redirect_unit.sv
// rtl/pc_redirect_unit.sv - fetch PC register with prioritized redirect and one-deep pending redirect buffer
module pc_redirect_unit #(
  parameter logic [31:0] PC_RESET   = 32'h0040_0000,
  parameter logic [31:0] EXC_VECTOR = 32'h8000_0080,
  parameter int          CNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  pc_redirect_unit_if.slave bus
);
  typedef enum logic {RUN, PEND} state_t;

  state_t           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      pend_q, pend_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [31:0] tgt;
  logic [31:0] pc_plus4;
  logic        redir;
  logic        br_sel;
  logic        flush;
  logic        fvalid;
  logic        pending;

  assign pc_plus4 = pc_q + 32'd4;

  // Exception > JumpReg > Jump > Branch_Hazard
  always_comb begin
    tgt = bus.BranchTarget;
    if (bus.Exception)    tgt = EXC_VECTOR;
    else if (bus.JumpReg) tgt = bus.JrTarget;
    else if (bus.Jump)    tgt = bus.JumpTarget;
  end

  assign br_sel = bus.Branch_Hazard & ~bus.Exception & ~bus.JumpReg & ~bus.Jump;
  assign redir  = bus.Exception |
                  (~bus.Stall & (bus.JumpReg | bus.Jump | bus.Branch_Hazard));

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    pend_d  = pend_q;
    cnt_d   = cnt_q;
    flush   = 1'b0;
    fvalid  = 1'b0;
    pending = 1'b0;
    case (state_q)
      RUN: begin
        flush  = redir;
        fvalid = bus.imem_ready & ~redir;
        if (redir) begin
          if (br_sel && cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + 1'b1;
          if (bus.imem_ready) begin
            pc_d = tgt;
          end else begin
            pend_d  = tgt;
            state_d = PEND;
          end
        end else if (!bus.Stall && bus.imem_ready) begin
          pc_d = pc_plus4;
        end
      end
      PEND: begin
        // ID holds a bubble here, so only an exception can replace the buffered target
        flush   = 1'b1;
        pending = 1'b1;
        if (bus.imem_ready) begin
          pc_d    = bus.Exception ? EXC_VECTOR : pend_q;
          state_d = RUN;
        end else if (bus.Exception) begin
          pend_d = EXC_VECTOR;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RUN;
      pc_q    <= PC_RESET;
      pend_q  <= 32'd0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.PC               = pc_q;
  assign bus.PC_plus4         = pc_plus4;
  assign bus.IFID_Flush       = flush;
  assign bus.fetch_valid      = fvalid;
  assign bus.redirect_pending = pending;
  assign bus.taken_cnt        = cnt_q;
endmodule

// File: tb/tb_pc_redirect_unit.sv
// tb/tb_pc_redirect_unit.sv - scoreboard bench for pc_redirect_unit with directed and random redirects
module tb_pc_redirect_unit;
  localparam int          CW   = 4;
  localparam logic [31:0] PRST = 32'h0040_0000;
  localparam logic [31:0] EXCV = 32'h8000_0080;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  pc_redirect_unit_if #(.CNT_W(CW)) bus ();

  pc_redirect_unit #(.PC_RESET(PRST), .EXC_VECTOR(EXCV), .CNT_W(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] p4;
    logic        flush;
    logic        fv;
    logic        rp;
    logic [31:0] cnt;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  // reference state: PC, an optional buffered redirect, and a plain integer counter
  logic [31:0] m_pc = PRST;
  bit          m_have_pend = 0;
  logic [31:0] m_pend = 32'd0;
  int          m_cnt = 0;

  logic s_rst, s_st, s_rdy, s_bh, s_j, s_jr, s_exc;
  logic [31:0] s_bt, s_jt, s_jrt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clr();
    s_rst = 1; s_st = 0; s_rdy = 1; s_bh = 0; s_j = 0; s_jr = 0; s_exc = 0;
    s_bt = 0; s_jt = 0; s_jrt = 0;
  endtask

  task automatic step();
    exp_t e;
    logic [31:0] t;
    bit is_br, want;
    @(posedge clk);
    #1;
    reset = s_rst;
    bus.Stall = s_st; bus.imem_ready = s_rdy; bus.Branch_Hazard = s_bh;
    bus.BranchTarget = s_bt; bus.Jump = s_j; bus.JumpTarget = s_jt;
    bus.JumpReg = s_jr; bus.JrTarget = s_jrt; bus.Exception = s_exc;
    if (!s_rst) begin
      m_pc = PRST; m_have_pend = 0; m_pend = 0; m_cnt = 0;
    end
    e.pc = m_pc; e.p4 = m_pc + 32'd4; e.cnt = m_cnt;
    if (m_have_pend) begin
      e.flush = 1; e.fv = 0; e.rp = 1;
      if (s_exc) m_pend = EXCV;
      if (s_rdy) begin m_pc = m_pend; m_have_pend = 0; end
    end else begin
      is_br = 0;
      if (s_exc)                t = EXCV;
      else if (s_jr && !s_st)   t = s_jrt;
      else if (s_j && !s_st)    t = s_jt;
      else if (s_bh && !s_st) begin t = s_bt; is_br = 1; end
      else                      t = 'x;
      want = s_exc || (!s_st && (s_jr || s_j || s_bh));
      e.flush = want; e.fv = s_rdy && !want; e.rp = 0;
      if (want) begin
        if (is_br) m_cnt = (m_cnt + 1 > 15) ? 15 : m_cnt + 1;
        if (s_rdy) m_pc = t;
        else begin m_pend = t; m_have_pend = 1; end
      end else if (!s_st && s_rdy) m_pc = m_pc + 32'd4;
    end
    if (!s_rst) begin
      m_pc = PRST; m_have_pend = 0; m_pend = 0; m_cnt = 0;
    end
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("pc", bus.PC, e.pc);
      chk("pc_plus4", bus.PC_plus4, e.p4);
      chk("ifid_flush", {31'd0, bus.IFID_Flush}, {31'd0, e.flush});
      chk("fetch_valid", {31'd0, bus.fetch_valid}, {31'd0, e.fv});
      chk("redirect_pending", {31'd0, bus.redirect_pending}, {31'd0, e.rp});
      chk("taken_cnt", {28'd0, bus.taken_cnt}, e.cnt);
    end
  end

  task automatic at_neg(input string name, input logic [31:0] act_sel, input logic [31:0] exp);
    chk(name, act_sel, exp);
  endtask

  initial begin
    int budget;
    clr();
    bus.Stall = 0; bus.imem_ready = 0; bus.Branch_Hazard = 0; bus.BranchTarget = 0;
    bus.Jump = 0; bus.JumpTarget = 0; bus.JumpReg = 0; bus.JrTarget = 0; bus.Exception = 0;
    s_rst = 0; s_rdy = 0; step(); step();
    @(negedge clk); at_neg("reset_pc", bus.PC, PRST);
    clr(); repeat (4) step();
    clr(); s_bh = 1; s_bt = 32'h0040_0100; step();
    @(negedge clk); at_neg("br_flush", {31'd0, bus.IFID_Flush}, 32'd1);
    clr(); step();
    @(negedge clk); at_neg("br_pc", bus.PC, 32'h0040_0100);
    at_neg("br_cnt", {28'd0, bus.taken_cnt}, 32'd1);
    clr(); s_bh = 1; s_st = 1; s_bt = 32'h0040_0180; step();
    @(negedge clk); at_neg("stall_noflush", {31'd0, bus.IFID_Flush}, 32'd0);
    clr(); s_bh = 1; s_bt = 32'h0040_0180; step();
    clr(); s_jr = 1; s_jrt = 32'h0040_0200; s_rdy = 0; step();
    clr(); s_rdy = 0; step(); step();
    @(negedge clk); at_neg("pend_flag", {31'd0, bus.redirect_pending}, 32'd1);
    clr(); step(); step();
    @(negedge clk); at_neg("jr_pc", bus.PC, 32'h0040_0200);
    clr(); s_jr = 1; s_jrt = 32'h0040_0300; s_rdy = 0; step();
    clr(); s_exc = 1; s_rdy = 0; step();
    clr(); step(); step();
    @(negedge clk); at_neg("exc_over_pend", bus.PC, EXCV);
    clr(); s_jr = 1; s_jrt = 32'h0040_0400; s_rdy = 0; step();
    clr(); s_rst = 0; s_rdy = 0; step();
    clr(); step();
    @(negedge clk); at_neg("reset_in_pend", bus.PC, PRST);
    clr(); s_jr = 1; s_jrt = 32'hFFFF_FFFC; step();
    clr(); step(); step();
    @(negedge clk); at_neg("pc_wrap", bus.PC, 32'h0);
    for (int i = 0; i < 16; i++) begin clr(); s_bh = 1; s_bt = 32'h0000_1000 + 32'(i * 8); step(); end
    clr(); s_bh = 1; s_j = 1; s_jt = 32'h0000_2000; step();
    clr(); step();
    @(negedge clk); at_neg("cnt_sat", {28'd0, bus.taken_cnt}, 32'hF);
    for (int i = 0; i < 400; i++) begin
      clr();
      s_rst = ($urandom_range(0, 99) != 0);
      s_st  = ($urandom_range(0, 3) == 0);
      s_rdy = ($urandom_range(0, 3) != 0);
      s_bh  = ($urandom_range(0, 3) == 0);
      s_j   = ($urandom_range(0, 7) == 0);
      s_jr  = ($urandom_range(0, 7) == 0);
      s_exc = ($urandom_range(0, 15) == 0);
      s_bt  = $urandom; s_jt = $urandom; s_jrt = $urandom;
      step();
    end
    clr(); s_rdy = 0;
    budget = 0;
    while (sb.size() > 0 && budget < 10) begin @(posedge clk); budget++; end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: actual=%0d pending expectations expected=0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
